// File: rtl/clk_gen_pkg.sv
// Shared definitions for the multi-channel clock generator: default sizes
// and the per-channel state encoding.
package clk_gen_pkg;

    localparam int CHANNELS_DEF = 4;
    localparam int DIV_W_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } chan_state_t;

endpackage

// File: rtl/clk_gen_multi_if.sv
// Bus between the clock generator and its consumer: enables and divide values in,
// divided clocks and rising-edge strobes out.
interface clk_gen_multi_if
    import clk_gen_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int DIV_W    = DIV_W_DEF
);

    logic [CHANNELS-1:0]       en;
    logic [CHANNELS*DIV_W-1:0] div_cfg;
    logic [CHANNELS-1:0]       clk_out;
    logic [CHANNELS-1:0]       tick;

    modport master (
        output en,
        output div_cfg,
        input  clk_out,
        input  tick
    );

    modport slave (
        input  en,
        input  div_cfg,
        output clk_out,
        output tick
    );

endinterface

// File: rtl/clk_gen_chan.sv
// One divided-clock channel: 50 % duty, half-period of div+1 cycles, glitch-free
// enable. Optional phase-align input when CLKGEN_PHASE_SYNC_EN is defined.
module clk_gen_chan
    import clk_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             C,
    input  logic             R_N,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
`ifdef CLKGEN_PHASE_SYNC_EN
    input  logic             sync,
`endif
    output logic             clk_out,
    output logic             tick
);

    chan_state_t      state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act_div;
    logic             sync_hit;
    logic             half_done;

`ifdef CLKGEN_PHASE_SYNC_EN
    assign sync_hit = sync & en;
`else
    assign sync_hit = 1'b0;
`endif

    assign half_done = (cnt == act_div);

    // The ratio is latched only on HIGH entry, so config changes never cut a period short.
    always_ff @(posedge C or negedge R_N) begin
        if (!R_N) begin
            state   <= IDLE;
            cnt     <= '0;
            act_div <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (sync_hit) begin
                state   <= HIGH;
                act_div <= div;
                cnt     <= '0;
                clk_out <= 1'b1;
                tick    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        cnt     <= '0;
                        clk_out <= 1'b0;
                        if (en) begin
                            state   <= HIGH;
                            act_div <= div;
                            clk_out <= 1'b1;
                            tick    <= 1'b1;
                        end
                    end
                    HIGH: begin
                        if (half_done) begin
                            state   <= LOW;
                            cnt     <= '0;
                            clk_out <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    LOW: begin
                        if (half_done) begin
                            cnt <= '0;
                            if (en) begin
                                state   <= HIGH;
                                act_div <= div;
                                clk_out <= 1'b1;
                                tick    <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        cnt     <= '0;
                        clk_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/clk_gen_multi.sv
// Multi-channel clock generator top: one clk_gen_chan per channel, each fed its
// slice of div_cfg. Define CLKGEN_PHASE_SYNC_EN to add the sync phase-align port.
module clk_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int DIV_W    = DIV_W_DEF
) (
    input  logic             C,
    input  logic             R_N,
`ifdef CLKGEN_PHASE_SYNC_EN
    input  logic             sync,
`endif
    clk_gen_multi_if.slave   bus
);

    logic [CHANNELS-1:0] clk_vec;
    logic [CHANNELS-1:0] tick_vec;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        clk_gen_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .C       (C),
            .R_N     (R_N),
            .en      (bus.en[i]),
            .div     (bus.div_cfg[i*DIV_W +: DIV_W]),
`ifdef CLKGEN_PHASE_SYNC_EN
            .sync    (sync),
`endif
            .clk_out (clk_vec[i]),
            .tick    (tick_vec[i])
        );
    end

    assign bus.clk_out = clk_vec;
    assign bus.tick    = tick_vec;

endmodule

// File: doc/clk_gen_multi.md
# clk_gen_multi

Parametrised multi-channel clock generator for the clock-generation subsystem. From one master clock it produces CHANNELS independent divided clocks, each with 50 % duty cycle, a programmable per-channel divide ratio, a glitch-free enable, and a one-cycle rising-edge strobe. Outputs are registered and built from the shared DFF-style flop cells, so it maps onto the existing synthesis cell library. Downstream blocks consume either the divided clock or the strobe.

## Interface
Parameters:
- CHANNELS, 4, number of independent output channels
- DIV_W, 8, width of each channel's half-period divide value

Ports:
- C  input  1  master clock, rising-edge
- R_N  input  1  asynchronous active-low reset
- en  input  CHANNELS  per-channel run enable
- div_cfg  input  CHANNELS*DIV_W  per-channel divide value d; channel i uses bits [i*DIV_W +: DIV_W]
- clk_out  output  CHANNELS  divided clocks, registered
- tick  output  CHANNELS  one-C-cycle pulse coincident with each clk_out rising edge
- sync  input  1  phase-align strobe; present only with CLKGEN_PHASE_SYNC_EN

## Operation
- Per-channel FSM states: IDLE, HIGH, LOW. Each channel has a half-period counter `cnt` (DIV_W bits) and a latched ratio `act_div`.
- Half-period = d+1 C cycles; full period = 2(d+1); d=0 gives C/2, d=2^DIV_W−1 gives period 2^(DIV_W+1).
- IDLE: clk_out=0, tick=0, cnt=0. Go to HIGH when en=1. Entering HIGH loads act_div←div_cfg, cnt←0, clk_out←1, tick←1.
- HIGH: cnt increments. At cnt==act_div: cnt←0, go to LOW, clk_out←0.
- LOW: cnt increments. At cnt==act_div: if en=1, enter HIGH with a reload, as above; else go to IDLE.
- div_cfg is sampled only when HIGH is entered. Mid-period changes take effect at the next period, which keeps them glitch-free.
- Deasserting en never truncates a period: the current HIGH+LOW completes, then clk_out stays 0. Reasserting en during that period continues seamlessly.
- Channels are fully independent. tick is never asserted outside a HIGH entry.

## Timing
- Reset (R_N=0, async): clk_out=0, tick=0, all FSMs IDLE, cnt=0, act_div=0. This takes effect immediately, mid-period included.
- First cycle with R_N=1 is a normal cycle.
- Latency: en sampled 1 at edge t gives clk_out=1 and tick=1 after edge t, i.e. one cycle from en.
- clk_out is high for exactly d+1 cycles, then low for exactly d+1 cycles. tick width is exactly 1 cycle.
- With d=0 and en held, tick is asserted every 2nd cycle.

## Configuration
- CLKGEN_PHASE_SYNC_EN defined:
  - The sync port exists.
  - sync=1 at an edge forces every channel with en=1 into HIGH entry: reload, cnt←0, clk_out←1, tick←1. All enabled channels become rising-edge aligned.
  - sync has priority over the normal FSM transition in that cycle.
  - Channels with en=0 ignore sync and follow the normal rules.
- Not defined: no sync port and no alignment logic. Behaviour is otherwise identical.

## Structure
- Package clk_gen_pkg holds:
  - DIV_W default
  - state encoding IDLE/HIGH/LOW as a 2-bit typedef
- Sub-module clk_gen_chan implements one channel: en, div slice, optional sync, clk_out, tick.
- The top level generates CHANNELS instances and slices div_cfg.

## Test plan
- Reset: assert R_N=0 mid-HIGH with d=3 → clk_out and tick are 0 immediately. After release with en=0, outputs stay 0.
- d=0, en=1 on ch0 → clk_out toggles every cycle (period 2); tick is 1 every 2nd cycle, first at the cycle after en.
- d=2 on ch1 → 3 cycles high, 3 low, repeating. Set d=255 on ch2 → period 512.
- Mid-period change: ch1 d=2, change to d=1 during HIGH → current period is 6 cycles, subsequent periods are 4.
- Glitch-free stop: drop en on the 2nd cycle of HIGH (d=3) → HIGH lasts 4 cycles, LOW 4 cycles, then clk_out stays 0 with no tick.
- With CLKGEN_PHASE_SYNC_EN: ch0 d=1, ch1 d=3, both free-running and misaligned, pulse sync → next cycle both clk_out=1 with tick=1. Rising edges then coincide every 8 cycles.
